// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage with branch resolution, data memory, write-back register
// and the combinational ALU-control decoder used by EX.
module memory_access_stage #(
    parameter int DMEM_WORDS = 256,
    parameter int ADDR_W     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instruction,
    input  logic [63:0] branchAddress,
    input  logic [63:0] Results,
    input  logic [63:0] Data2,
    input  logic        zero,
    input  logic        B,
    input  logic        BZ,
    input  logic        BNZ,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    output logic [63:0] oldBranchAddress,
    output logic        PCSrc,
    output logic        oldRegWrite,
    output logic [63:0] Data2Write,
    output logic [4:0]  Reg2Write,
    input  logic [10:0] aluOpcode,
    input  logic [1:0]  ALUOp,
    output logic [3:0]  ALUInstr,
    output logic        aluIllegal
);
    logic [63:0]       mem [DMEM_WORDS];
    logic [ADDR_W-1:0] idx;
    logic [63:0]       load_data;

    assign idx              = Results[ADDR_W+2:3];
    assign load_data        = MemRead ? mem[idx] : '0;
    assign oldBranchAddress = branchAddress;
    assign PCSrc            = reset_n & (B | (BZ & zero) | (BNZ & ~zero));

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (MemWrite) mem[idx] <= Data2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oldRegWrite <= 1'b0;
            Data2Write  <= '0;
            Reg2Write   <= '0;
        end else begin
            oldRegWrite <= RegWrite & (Instruction[4:0] != 5'd31);
            Data2Write  <= MemToReg ? load_data : Results;
            Reg2Write   <= Instruction[4:0];
        end
    end

    // I-type opcodes carry a don't-care LSB, so only [10:1] is matched.
    always_comb begin
        ALUInstr = 4'b1111;
        case (ALUOp)
            2'b00: ALUInstr = 4'b0010;
            2'b01: ALUInstr = 4'b0111;
            2'b10: case (aluOpcode)
                11'b10001011000: ALUInstr = 4'b0010;
                11'b11001011000: ALUInstr = 4'b0110;
                11'b10001010000: ALUInstr = 4'b0000;
                11'b10101010000: ALUInstr = 4'b0001;
                default:         ALUInstr = 4'b1111;
            endcase
            default: case (aluOpcode[10:1])
                10'b1001000100: ALUInstr = 4'b0010;
                10'b1101000100: ALUInstr = 4'b0110;
                10'b1001001000: ALUInstr = 4'b0000;
                10'b1011001000: ALUInstr = 4'b0001;
                default:        ALUInstr = 4'b1111;
            endcase
        endcase
        aluIllegal = ALUInstr == 4'b1111;
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: scoreboard bench; stimulus queues expected write-back
// bundles, a monitor pops and compares one per clock edge.
module tb_memory_access_stage;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [31:0] Instruction = '0;
    logic [63:0] branchAddress = '0;
    logic [63:0] Results = '0;
    logic [63:0] Data2 = '0;
    logic        zero = 0, B = 0, BZ = 0, BNZ = 0;
    logic        MemRead = 0, MemWrite = 0, MemToReg = 0, RegWrite = 0;
    logic [63:0] oldBranchAddress;
    logic        PCSrc, oldRegWrite;
    logic [63:0] Data2Write;
    logic [4:0]  Reg2Write;
    logic [10:0] aluOpcode = '0;
    logic [1:0]  ALUOp = '0;
    logic [3:0]  ALUInstr;
    logic        aluIllegal;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  r;
        logic        w;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    memory_access_stage dut (
        .clk(clk), .reset_n(reset_n), .Instruction(Instruction),
        .branchAddress(branchAddress), .Results(Results), .Data2(Data2),
        .zero(zero), .B(B), .BZ(BZ), .BNZ(BNZ), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .oldBranchAddress(oldBranchAddress), .PCSrc(PCSrc),
        .oldRegWrite(oldRegWrite), .Data2Write(Data2Write), .Reg2Write(Reg2Write),
        .aluOpcode(aluOpcode), .ALUOp(ALUOp), .ALUInstr(ALUInstr), .aluIllegal(aluIllegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one write-back bundle per edge while expectations are pending.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("wb_data", Data2Write, e.d);
            chk("wb_reg", {59'd0, Reg2Write}, {59'd0, e.r});
            chk("wb_regwrite", {63'd0, oldRegWrite}, {63'd0, e.w});
        end
    end

    task automatic step(input logic [63:0] res, input logic [63:0] d2, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic [63:0] exp_d, input logic exp_w);
        exp_t e;
        @(negedge clk);
        Results = res;
        Data2 = d2;
        Instruction = {27'h5a5a5a5, rd};
        MemRead = mr;
        MemWrite = mw;
        MemToReg = m2r;
        RegWrite = rw;
        e.d = exp_d;
        e.r = rd;
        e.w = exp_w;
        q.push_back(e);
        @(posedge clk);
        #2;
        MemWrite = 0;
    endtask

    task automatic br(input logic b, input logic bz, input logic bnz, input logic z,
                      input logic [63:0] tgt, input logic exp);
        B = b;
        BZ = bz;
        BNZ = bnz;
        zero = z;
        branchAddress = tgt;
        #1;
        chk("pcsrc", {63'd0, PCSrc}, {63'd0, exp});
        chk("branch_addr", oldBranchAddress, tgt);
    endtask

    task automatic alu(input logic [10:0] op, input logic [1:0] aop,
                       input logic [3:0] exp_i, input logic exp_ill);
        aluOpcode = op;
        ALUOp = aop;
        #1;
        chk("alu_instr", {60'd0, ALUInstr}, {60'd0, exp_i});
        chk("alu_illegal", {63'd0, aluIllegal}, {63'd0, exp_ill});
    endtask

    initial begin
        #2;
        chk("rst_data", Data2Write, 64'd0);
        chk("rst_reg", {59'd0, Reg2Write}, 64'd0);
        chk("rst_regwrite", {63'd0, oldRegWrite}, 64'd0);
        B = 1;
        #1;
        chk("rst_pcsrc", {63'd0, PCSrc}, 64'd0);
        B = 0;
        @(negedge clk);
        reset_n = 1;

        step(64'h10, 64'hDEADBEEF_CAFEF00D, 5'd0, 0, 1, 0, 0, 64'h10, 0);
        step(64'h17, 64'd0, 5'd5, 1, 0, 1, 1, 64'hDEADBEEF_CAFEF00D, 1);
        step(64'h0, 64'h1111_2222_3333_4444, 5'd1, 0, 1, 0, 1, 64'h0, 1);
        step(64'h800, 64'h5555_6666_7777_8888, 5'd2, 1, 1, 1, 1, 64'h1111_2222_3333_4444, 1);
        step(64'h0, 64'd0, 5'd3, 1, 0, 1, 1, 64'h5555_6666_7777_8888, 1);
        step(64'h40, 64'd0, 5'd31, 0, 0, 0, 1, 64'h40, 0);
        step(64'h10, 64'd0, 5'd7, 0, 0, 1, 1, 64'h0, 0 | 1);
        step(64'h1234_5678_9ABC_DEF0, 64'd0, 5'd9, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 0);

        br(1, 0, 0, 0, 64'h0000_0000_0040_1000, 1);
        br(0, 1, 0, 1, 64'hFFFF_0000_1234_0008, 1);
        br(0, 1, 0, 0, 64'h0000_0000_0000_0100, 0);
        br(0, 0, 1, 0, 64'h8000_0000_0000_0004, 1);
        br(0, 0, 1, 1, 64'h0000_0000_0000_0200, 0);
        br(0, 0, 0, 1, 64'h0000_0000_ABCD_0000, 0);

        alu(11'b11111111111, 2'b00, 4'b0010, 0);
        alu(11'b00000000000, 2'b01, 4'b0111, 0);
        alu(11'b10001011000, 2'b10, 4'b0010, 0);
        alu(11'b11001011000, 2'b10, 4'b0110, 0);
        alu(11'b10001010000, 2'b10, 4'b0000, 0);
        alu(11'b10101010000, 2'b10, 4'b0001, 0);
        alu(11'b10010001000, 2'b11, 4'b0010, 0);
        alu(11'b10010001001, 2'b11, 4'b0010, 0);
        alu(11'b11010001000, 2'b11, 4'b0110, 0);
        alu(11'b10010010000, 2'b11, 4'b0000, 0);
        alu(11'b10110010001, 2'b11, 4'b0001, 0);
        alu(11'b00000000000, 2'b10, 4'b1111, 1);
        alu(11'b10001011000, 2'b11, 4'b1111, 1);

        // Reset asserted between edges must clear outputs immediately.
        B = 1;
        step(64'h99, 64'd0, 5'd3, 0, 0, 0, 1, 64'h99, 1);
        #1;
        chk("pre_rst_pcsrc", {63'd0, PCSrc}, 64'd1);
        reset_n = 0;
        #1;
        chk("mid_rst_data", Data2Write, 64'd0);
        chk("mid_rst_reg", {59'd0, Reg2Write}, 64'd0);
        chk("mid_rst_regwrite", {63'd0, oldRegWrite}, 64'd0);
        chk("mid_rst_pcsrc", {63'd0, PCSrc}, 64'd0);
        B = 0;
        RegWrite = 0;
        @(negedge clk);
        reset_n = 1;

        // Memory survives reset: word 2 still holds the first store.
        step(64'h10, 64'd0, 5'd4, 1, 0, 1, 1, 64'hDEADBEEF_CAFEF00D, 1);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
